// File: rtl/mmio_pkg.sv
// Shared types and default memory map for the MMIO decode router.
// The default windows are DMEM, two I/O blocks and a spare high window.
package mmio_pkg;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_UNMAPPED = 2'd1,
    RSP_TIMEOUT  = 2'd2,
    RSP_WRPROT   = 2'd3
  } rsp_code_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam int DEF_NUM_REGIONS = 4;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 16;

  // Region 0 sits in the least significant slice.
  localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_BASE =
    {32'h2000_0000, 32'h1001_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_MASK =
    {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F800};
  localparam logic [DEF_NUM_REGIONS-1:0] DEF_REGION_RO = 4'b0100;

  // Wide enough to hold TIMEOUT_CYC-1, never narrower than one bit.
  function automatic int cnt_width(input int timeout_cyc);
    return (timeout_cyc > 2) ? $clog2(timeout_cyc) : 1;
  endfunction

  function automatic int idx_width(input int num_regions);
    return (num_regions > 1) ? $clog2(num_regions) : 1;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_TIMEOUT_CYC);

endpackage

// File: rtl/mmio_region_match.sv
// Combinational base/mask window compare with lowest-index priority.
// Reports whether any window hit, which one, and its read-only flag.
module mmio_region_match
  import mmio_pkg::*;
#(
  parameter int                                NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int                                ADDR_W      = DEF_ADDR_W,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]     REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0]     REGION_MASK = DEF_REGION_MASK,
  parameter logic [NUM_REGIONS-1:0]            REGION_RO   = DEF_REGION_RO,
  localparam int                               IDX_W       = idx_width(NUM_REGIONS)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic              ro
);

  // NOTE: every output gets a default before the loop, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    ro  = 1'b0;
    // Scanning from the top down lets the lowest matching index overwrite.
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if ((addr & REGION_MASK[r*ADDR_W +: ADDR_W]) == REGION_BASE[r*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        idx = IDX_W'(r);
        ro  = REGION_RO[r];
      end
    end
  end

endmodule

// File: rtl/mmio_decode_router.sv
// LSU-to-slave MMIO router: decodes one request against programmable windows,
// issues it to a single slave and returns data or a coded error.
module mmio_decode_router
  import mmio_pkg::*;
#(
  parameter int                            NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int                            ADDR_W      = DEF_ADDR_W,
  parameter int                            DATA_W      = DEF_DATA_W,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEF_REGION_MASK,
  parameter logic [NUM_REGIONS-1:0]        REGION_RO   = DEF_REGION_RO,
  parameter int                            TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic [ADDR_W-1:0]             i_req_addr,
  input  logic                          i_req_wren,
  input  logic [DATA_W-1:0]             i_req_wdata,
  input  logic [DATA_W/8-1:0]           i_req_bmask,
  output logic                          o_rsp_valid,
  output logic [DATA_W-1:0]             o_rsp_rdata,
  output logic                          o_rsp_err,
  output logic [1:0]                    o_rsp_code,
  output logic [NUM_REGIONS-1:0]        o_slv_valid,
  output logic                          o_slv_wren,
  output logic [ADDR_W-1:0]             o_slv_addr,
  output logic [DATA_W-1:0]             o_slv_wdata,
  output logic [DATA_W/8-1:0]           o_slv_bmask,
  input  logic [NUM_REGIONS-1:0]        i_slv_ack,
  input  logic [NUM_REGIONS*DATA_W-1:0] i_slv_rdata,
  output logic                          o_busy
);

  localparam int               IDX_W    = idx_width(NUM_REGIONS);
  localparam int               BM_W     = DATA_W / 8;
  localparam int               CNT_W    = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e                   state_q, state_d;
  logic                     dec_hit;
  logic [IDX_W-1:0]         dec_idx;
  logic                     dec_ro;

  logic [IDX_W-1:0]         sel_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [NUM_REGIONS-1:0]   slv_valid_q;
  logic                     wren_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [BM_W-1:0]          bmask_q;

  logic [DATA_W-1:0]        rsp_rdata_q;
  logic                     rsp_err_q;
  rsp_code_e                rsp_code_q;

  logic                     sel_ack;
  logic [DATA_W-1:0]        sel_rdata;
  logic                     issue;
  logic                     rsp_load;
  rsp_code_e                rsp_code_d;
  logic [DATA_W-1:0]        rsp_rdata_d;

  mmio_region_match #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .REGION_RO   (REGION_RO)
  ) u_match (
    .addr (i_req_addr),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .ro   (dec_ro)
  );

  // Only the selected slave's ack and read-data slice are ever observed.
  assign sel_ack   = i_slv_ack[sel_q];
  assign sel_rdata = i_slv_rdata[sel_q*DATA_W +: DATA_W];

  always_comb begin
    state_d     = state_q;
    issue       = 1'b0;
    rsp_load    = 1'b0;
    rsp_code_d  = RSP_OK;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          if (!dec_hit) begin
            state_d    = RESP;
            rsp_load   = 1'b1;
            rsp_code_d = RSP_UNMAPPED;
          end else if (dec_ro && i_req_wren) begin
            state_d    = RESP;
            rsp_load   = 1'b1;
            rsp_code_d = RSP_WRPROT;
          end else begin
            state_d = ISSUE;
            issue   = 1'b1;
          end
        end
      end
      ISSUE: begin
        // A late ack in the final counted cycle still completes normally.
        if (sel_ack) begin
          state_d     = RESP;
          rsp_load    = 1'b1;
          rsp_code_d  = RSP_OK;
          rsp_rdata_d = wren_q ? '0 : sel_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = RESP;
          rsp_load   = 1'b1;
          rsp_code_d = RSP_TIMEOUT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sel_q       <= '0;
      cnt_q       <= '0;
      slv_valid_q <= '0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bmask_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_code_q  <= RSP_OK;
    end else begin
      if (state_q == IDLE && i_req_valid) begin
        wren_q  <= i_req_wren;
        addr_q  <= i_req_addr;
        wdata_q <= i_req_wdata;
        bmask_q <= i_req_bmask;
      end

      if (issue) begin
        sel_q       <= dec_idx;
        slv_valid_q <= NUM_REGIONS'(1) << dec_idx;
      end else if (state_q == ISSUE && state_d != ISSUE) begin
        slv_valid_q <= '0;
      end

      cnt_q <= (state_q == ISSUE) ? cnt_q + 1'b1 : '0;

      // Response fields persist between pulses; only o_rsp_valid strobes.
      if (rsp_load) begin
        rsp_code_q  <= rsp_code_d;
        rsp_err_q   <= (rsp_code_d != RSP_OK);
        rsp_rdata_q <= rsp_rdata_d;
      end
    end
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_busy      = (state_q != IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_code  = rsp_code_q;
  assign o_slv_valid = slv_valid_q;
  assign o_slv_wren  = wren_q;
  assign o_slv_addr  = addr_q;
  assign o_slv_wdata = wdata_q;
  assign o_slv_bmask = bmask_q;

endmodule

// File: tb/tb_mmio_decode_router.sv
// Directed bench for mmio_decode_router: table of transactions with
// hand-computed strobes, latencies and responses, plus a mid-flight reset.
module tb_mmio_decode_router;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_addr;
  logic         req_wren;
  logic [31:0]  req_wdata;
  logic [3:0]   req_bmask;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [1:0]   rsp_code;
  logic [3:0]   slv_valid;
  logic         slv_wren;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_bmask;
  logic [3:0]   slv_ack;
  logic [127:0] slv_rdata;
  logic         busy;

  int checks = 0;
  int errors = 0;

  mmio_decode_router dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_wren  (req_wren),
    .i_req_wdata (req_wdata),
    .i_req_bmask (req_bmask),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_rsp_code  (rsp_code),
    .o_slv_valid (slv_valid),
    .o_slv_wren  (slv_wren),
    .o_slv_addr  (slv_addr),
    .o_slv_wdata (slv_wdata),
    .o_slv_bmask (slv_bmask),
    .i_slv_ack   (slv_ack),
    .i_slv_rdata (slv_rdata),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wren;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    int          ack_cyc;     // strobe cycle in which the selected slave acks, 0 = never
    logic [31:0] ack_data;
    logic [3:0]  noise_ack;   // acks raised on other slaves every cycle
    logic [3:0]  exp_sel;
    int          exp_strobe;  // number of cycles o_slv_valid is expected high
    int          exp_lat;     // response cycle, request accepted at cycle 0
    logic [1:0]  exp_code;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input logic [31:0] addr, input logic wren,
                              input logic [31:0] wdata, input logic [3:0] bmask,
                              input int ack_cyc, input logic [31:0] ack_data,
                              input logic [3:0] noise_ack, input logic [3:0] exp_sel,
                              input int exp_strobe, input int exp_lat,
                              input logic [1:0] exp_code, input logic [31:0] exp_rdata);
    vec_t v;
    v.addr = addr;  v.wren = wren;  v.wdata = wdata;  v.bmask = bmask;
    v.ack_cyc = ack_cyc;  v.ack_data = ack_data;  v.noise_ack = noise_ack;
    v.exp_sel = exp_sel;  v.exp_strobe = exp_strobe;  v.exp_lat = exp_lat;
    v.exp_code = exp_code;  v.exp_rdata = exp_rdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered at a negedge in the cycle the request is presented (cycle 0);
  // returns at the negedge of the first idle cycle after the response.
  task automatic run_vec(input vec_t v, input string tag);
    logic [3:0] exp_sv;
    check({tag, ".ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_wren  = v.wren;
    req_wdata = v.wdata;
    req_bmask = v.bmask;
    for (int cyc = 1; cyc <= v.exp_lat + 1; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0;
      exp_sv = (cyc <= v.exp_strobe) ? v.exp_sel : 4'b0000;
      check($sformatf("%s.c%0d.slv_valid", tag, cyc), 64'(slv_valid), 64'(exp_sv));
      check($sformatf("%s.c%0d.rsp_valid", tag, cyc), 64'(rsp_valid), 64'(cyc == v.exp_lat));
      check($sformatf("%s.c%0d.busy", tag, cyc), 64'(busy), 64'(cyc <= v.exp_lat));
      if (cyc == 1 && v.exp_sel != 4'b0000) begin
        check({tag, ".slv_addr"},  64'(slv_addr),  64'(v.addr));
        check({tag, ".slv_wren"},  64'(slv_wren),  64'(v.wren));
        check({tag, ".slv_wdata"}, 64'(slv_wdata), 64'(v.wdata));
        check({tag, ".slv_bmask"}, 64'(slv_bmask), 64'(v.bmask));
      end
      if (cyc == v.exp_lat) begin
        check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
        check({tag, ".rsp_code"},  64'(rsp_code),  64'(v.exp_code));
        check({tag, ".rsp_err"},   64'(rsp_err),   64'(v.exp_code != 2'd0));
      end
      if (cyc == v.exp_lat + 1) begin
        check({tag, ".code_hold"},  64'(rsp_code),  64'(v.exp_code));
        check({tag, ".rdata_hold"}, 64'(rsp_rdata), 64'(v.exp_rdata));
      end
      slv_ack = v.noise_ack | ((cyc == v.ack_cyc) ? v.exp_sel : 4'b0000);
      for (int r = 0; r < 4; r++)
        slv_rdata[r*32 +: 32] = v.exp_sel[r] ? v.ack_data : (32'hBAD0_0000 | 32'(r));
    end
    slv_ack = 4'b0000;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wren  = 1'b0;
    req_wdata = '0;
    req_bmask = '0;
    slv_ack   = '0;
    slv_rdata = '0;

    //            addr          wr    wdata         bm       ack data          noise    sel      stb lat code  rdata
    vecs[0] = mk(32'h0000_0004, 1'b0, 32'h0,        4'hF,    1, 32'hDEAD_BEEF, 4'b0000, 4'b0001, 1,  2, 2'd0, 32'hDEAD_BEEF);
    vecs[1] = mk(32'h3000_0000, 1'b0, 32'h0,        4'hF,    0, 32'h0,         4'b0000, 4'b0000, 0,  1, 2'd1, 32'h0);
    vecs[2] = mk(32'h1000_0010, 1'b1, 32'h0000_00FF, 4'b0001, 3, 32'h1234_5678, 4'b0000, 4'b0010, 3,  4, 2'd0, 32'h0);
    vecs[3] = mk(32'h1001_0000, 1'b1, 32'hA5A5_A5A5, 4'hF,    0, 32'h0,         4'b0000, 4'b0000, 0,  1, 2'd3, 32'h0);
    vecs[4] = mk(32'h0000_0800, 1'b0, 32'h0,        4'hF,    0, 32'h0,         4'b0000, 4'b0000, 0,  1, 2'd1, 32'h0);
    vecs[5] = mk(32'h0000_07FC, 1'b0, 32'h0,        4'hF,    1, 32'h0102_0304, 4'b0000, 4'b0001, 1,  2, 2'd0, 32'h0102_0304);
    vecs[6] = mk(32'h2000_1234, 1'b0, 32'h0,        4'hF,    2, 32'hCAFE_F00D, 4'b0000, 4'b1000, 2,  3, 2'd0, 32'hCAFE_F00D);
    vecs[7] = mk(32'h1001_0000, 1'b0, 32'h0,        4'hF,    1, 32'h5555_AAAA, 4'b0000, 4'b0100, 1,  2, 2'd0, 32'h5555_AAAA);
    vecs[8] = mk(32'h1001_0008, 1'b0, 32'h0,        4'hF,   16, 32'h0BAD_CAFE, 4'b0000, 4'b0100, 16, 17, 2'd0, 32'h0BAD_CAFE);
    vecs[9] = mk(32'h1001_0004, 1'b0, 32'h0,        4'hF,    0, 32'h7777_7777, 4'b0001, 4'b0100, 16, 17, 2'd2, 32'h0);

    repeat (2) @(negedge clk);
    check("reset.ready",     64'(req_ready), 64'd1);
    check("reset.busy",      64'(busy),      64'd0);
    check("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset.slv_valid", 64'(slv_valid), 64'd0);
    check("reset.rsp_code",  64'(rsp_code),  64'd0);
    check("reset.rsp_rdata", 64'(rsp_rdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: each vector is presented in the cycle right after the previous response.
    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset asserted while a read to slave 1 is waiting for its ack.
    req_valid = 1'b1;
    req_addr  = 32'h1000_0020;
    req_wren  = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid.strobe", 64'(slv_valid), 64'b0010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid.slv_valid", 64'(slv_valid), 64'd0);
    check("rst_mid.busy",      64'(busy),      64'd0);
    check("rst_mid.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_mid.ready",     64'(req_ready), 64'd1);
    check("rst_mid.rsp_code",  64'(rsp_code),  64'd0);
    check("rst_mid.rsp_err",   64'(rsp_err),   64'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d.rsp_valid", c), 64'(rsp_valid), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rel.busy",      64'(busy),      64'd0);
    run_vec(mk(32'h0000_0000, 1'b0, 32'h0, 4'hF, 1, 32'h600D_F00D, 4'b0000,
               4'b0001, 1, 2, 2'd0, 32'h600D_F00D), "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
